// File: rtl/param_regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the parametrised register file:
//   - clear-sequencer state encoding
//   - default geometry (DATA_W / NUM_REGS)
//   - clog2 helper used for elaboration-time address-width checks
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  // Smallest n with 2**n >= value (value >= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/param_regfile_if.sv
// -----------------------------------------------------------------------------
// param_regfile_if
// Bundles the write port, both read ports and the clear handshake of
// param_regfile.
//   master : drives wr_en/wr_addr/wr_data, rd_addr_a/b, clr_req;
//            observes wr_ready, rd_data_a/b, clr_busy, clr_done
//   slave  : the register file itself (directions reversed)
// -----------------------------------------------------------------------------
interface param_regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 4
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    input  wr_ready, rd_data_a, rd_data_b, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    output wr_ready, rd_data_a, rd_data_b, clr_busy, clr_done
  );

endinterface

// File: rtl/param_regfile_clear_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clear_fsm
// Software-triggered clear sequencer. Walks a pointer over r0..r(NUM_REGS-1),
// one register per cycle, and then emits a single-cycle done pulse.
// Ports:
//   clk, reset      clock / async active-high reset
//   clr_req    in   start request, sampled only in IDLE
//   wr_ready   out  external write port may accept (low while sweeping)
//   clr_busy   out  sweep in progress
//   clr_done   out  one-cycle pulse after the last register is cleared
//   clr_we     out  clear-write strobe to the storage array
//   clr_addr   out  register being cleared this cycle
// -----------------------------------------------------------------------------
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              wr_ready,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, independent
      // of statement order or of other always_ff blocks.
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default up front so no path through the case
    // leaves a variable unassigned (which would infer a latch).
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_ready = 1'b1;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    clr_addr = ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end

      ST_CLEAR: begin
        wr_ready = 1'b0;
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        // Stop on the last real register so the pointer never leaves the
        // populated range even when NUM_REGS is not a power of two.
        if (ptr_q == LAST_PTR) begin
          state_d = ST_DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end

      ST_DONE: begin
        clr_done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/param_regfile.sv
// -----------------------------------------------------------------------------
// param_regfile
// Parametrised register file: one encoded-address write port, two
// combinational read ports with optional write-through bypass, optional
// hardwired-zero r0 and a multi-cycle clear sweep.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset; loads RESET_VAL everywhere
//   bus    slave modport of param_regfile_if:
//            wr_en/wr_addr/wr_data  -> write request (accepted when wr_ready)
//            wr_ready               <- low during the clear sweep
//            rd_addr_a/rd_data_a    -> / <- read port A (combinational)
//            rd_addr_b/rd_data_b    -> / <- read port B (combinational)
//            clr_req                -> start clear sweep
//            clr_busy/clr_done      <- sweep status / completion pulse
// -----------------------------------------------------------------------------
module param_regfile
  import regfile_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                NUM_REGS  = DEF_NUM_REGS,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                ZERO_R0   = 1'b0,
  parameter bit                BYPASS    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  param_regfile_if.slave  bus
);

  if (NUM_REGS < 2 || NUM_REGS > 256) begin : g_bad_num_regs
    $error("param_regfile: NUM_REGS must be in 2..256");
  end
  if (ADDR_W < clog2(NUM_REGS)) begin : g_bad_addr_w
    $error("param_regfile: ADDR_W too narrow for NUM_REGS");
  end

  // One extra bit so NUM_REGS = 2**ADDR_W still fits in the range compare.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              wr_ready;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_in_range;
  logic              wr_is_r0;
  logic              wr_accept;

  regfile_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (bus.clr_req),
    .wr_ready (wr_ready),
    .clr_busy (bus.clr_busy),
    .clr_done (bus.clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.wr_ready = wr_ready;

  assign wr_in_range = ({1'b0, bus.wr_addr} < NUM_REGS_W);
  assign wr_is_r0    = ZERO_R0 && (bus.wr_addr == '0);
  // Dropped writes (port busy, out of range, hardwired r0) never touch the
  // array and never feed the bypass path.
  assign wr_accept   = bus.wr_en && wr_ready && wr_in_range && !wr_is_r0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this is a flop array, not a RAM macro, so every entry gets the
      // async reset; a real SRAM could not be cleared this way.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (clr_we) begin
      regs_q[clr_addr] <= RESET_VAL;
    end else if (wr_accept) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read mux shared by both ports. clr_we and wr_accept are mutually
  // exclusive (wr_ready is low while sweeping), so the bypass is naturally
  // suppressed during the sweep.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              fwd_hit,
    input logic [DATA_W-1:0] fwd_data
  );
    if ({1'b0, addr} >= NUM_REGS_W) return '0;
    if (ZERO_R0 && (addr == '0))    return '0;
    if (BYPASS && fwd_hit)          return fwd_data;
    return stored;
  endfunction

  assign bus.rd_data_a = read_port(bus.rd_addr_a, regs_q[bus.rd_addr_a],
                                   wr_accept && (bus.wr_addr == bus.rd_addr_a),
                                   bus.wr_data);
  assign bus.rd_data_b = read_port(bus.rd_addr_b, regs_q[bus.rd_addr_b],
                                   wr_accept && (bus.wr_addr == bus.rd_addr_b),
                                   bus.wr_data);

endmodule

// File: tb/tb_param_regfile.sv
// -----------------------------------------------------------------------------
// tb_param_regfile
// Three register-file builds driven by identical stimulus:
//   d0: 16 regs, RESET_VAL 0,    ZERO_R0 0, BYPASS 1
//   d1: 16 regs, RESET_VAL 0,    ZERO_R0 0, BYPASS 0
//   d2: 12 regs, RESET_VAL 5a5a, ZERO_R0 1, BYPASS 1
// Each build is compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_param_regfile;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic        clr_req;

  logic [15:0] o_rd_a [NDUT];
  logic [15:0] o_rd_b [NDUT];
  logic        o_ready[NDUT];
  logic        o_busy [NDUT];
  logic        o_done [NDUT];

  always #5 clk = ~clk;

  param_regfile_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
  param_regfile_if #(.DATA_W(16), .ADDR_W(4)) if1 ();
  param_regfile_if #(.DATA_W(16), .ADDR_W(4)) if2 ();

  param_regfile #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .RESET_VAL(16'h0000),
                  .ZERO_R0(1'b0), .BYPASS(1'b1))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  param_regfile #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .RESET_VAL(16'h0000),
                  .ZERO_R0(1'b0), .BYPASS(1'b0))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  param_regfile #(.DATA_W(16), .NUM_REGS(12), .ADDR_W(4), .RESET_VAL(16'h5a5a),
                  .ZERO_R0(1'b1), .BYPASS(1'b1))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.wr_en = wr_en;     assign if1.wr_en = wr_en;     assign if2.wr_en = wr_en;
  assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr; assign if2.wr_addr = wr_addr;
  assign if0.wr_data = wr_data; assign if1.wr_data = wr_data; assign if2.wr_data = wr_data;
  assign if0.rd_addr_a = rd_addr_a; assign if1.rd_addr_a = rd_addr_a; assign if2.rd_addr_a = rd_addr_a;
  assign if0.rd_addr_b = rd_addr_b; assign if1.rd_addr_b = rd_addr_b; assign if2.rd_addr_b = rd_addr_b;
  assign if0.clr_req = clr_req; assign if1.clr_req = clr_req; assign if2.clr_req = clr_req;

  assign o_rd_a[0] = if0.rd_data_a; assign o_rd_a[1] = if1.rd_data_a; assign o_rd_a[2] = if2.rd_data_a;
  assign o_rd_b[0] = if0.rd_data_b; assign o_rd_b[1] = if1.rd_data_b; assign o_rd_b[2] = if2.rd_data_b;
  assign o_ready[0] = if0.wr_ready; assign o_ready[1] = if1.wr_ready; assign o_ready[2] = if2.wr_ready;
  assign o_busy[0] = if0.clr_busy;  assign o_busy[1] = if1.clr_busy;  assign o_busy[2] = if2.clr_busy;
  assign o_done[0] = if0.clr_done;  assign o_done[1] = if1.clr_done;  assign o_done[2] = if2.clr_done;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int          cfg_n    [NDUT] = '{16, 16, 12};
  bit          cfg_zero [NDUT] = '{1'b0, 1'b0, 1'b1};
  bit          cfg_byp  [NDUT] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] cfg_rv   [NDUT] = '{16'h0000, 16'h0000, 16'h5a5a};

  logic [15:0] mdl_mem  [NDUT][16];
  int          mdl_sweep[NDUT];  // -1 when not sweeping, else next index to clear
  bit          mdl_done [NDUT];  // done pulse owed this cycle

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit mdl_accepts(input int c);
    return wr_en && (mdl_sweep[c] < 0) && (int'(wr_addr) < cfg_n[c]) &&
           !(cfg_zero[c] && wr_addr == 4'd0);
  endfunction

  function automatic logic [15:0] mdl_read(input int c, input logic [3:0] a);
    if (int'(a) >= cfg_n[c]) return 16'h0000;
    if (cfg_zero[c] && a == 4'd0) return 16'h0000;
    if (cfg_byp[c] && mdl_accepts(c) && wr_addr == a) return wr_data;
    return mdl_mem[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NDUT; c++) begin
      for (int r = 0; r < 16; r++) mdl_mem[c][r] = cfg_rv[c];
      mdl_sweep[c] = -1;
      mdl_done[c]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NDUT; c++) begin
      if (mdl_accepts(c)) mdl_mem[c][wr_addr] = wr_data;
      if (mdl_sweep[c] >= 0) begin
        mdl_mem[c][mdl_sweep[c]] = cfg_rv[c];
        if (mdl_sweep[c] == cfg_n[c] - 1) begin
          mdl_sweep[c] = -1;
          mdl_done[c]  = 1'b1;
        end else begin
          mdl_sweep[c]++;
        end
      end else if (mdl_done[c]) begin
        mdl_done[c] = 1'b0;
      end else if (clr_req) begin
        mdl_sweep[c] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NDUT; c++) begin
      check($sformatf("d%0d rd_a[%0d]", c, rd_addr_a), 32'(o_rd_a[c]), 32'(mdl_read(c, rd_addr_a)));
      check($sformatf("d%0d rd_b[%0d]", c, rd_addr_b), 32'(o_rd_b[c]), 32'(mdl_read(c, rd_addr_b)));
      check($sformatf("d%0d wr_ready", c), 32'(o_ready[c]), 32'(mdl_sweep[c] < 0));
      check($sformatf("d%0d clr_busy", c), 32'(o_busy[c]), 32'(mdl_sweep[c] >= 0));
      check($sformatf("d%0d clr_done", c), 32'(o_done[c]), 32'(mdl_done[c]));
    end
  endtask

  // One clock: let the model follow the rising edge, then drive new inputs on
  // the falling edge and compare 1 time unit later.
  task automatic cycle(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [3:0] ra, input logic [3:0] rb, input logic cr);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb; clr_req = cr;
    #1;
    check_all();
  endtask

  // Asserts reset at the current (non-edge) time, checks the immediate effect,
  // sweeps all addresses while held, then releases between edges.
  task automatic apply_reset();
    reset = 1'b1; wr_en = 1'b0; clr_req = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    #1;
    check_all();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rd_addr_a = 4'(a); rd_addr_b = 4'(15 - a);
      #1;
      check_all();
    end
    #2 reset = 1'b0;
  endtask

  int nbusy[NDUT];
  int ndone[NDUT];

  initial begin
    rd_addr_a = '0; rd_addr_b = '0;
    apply_reset();

    // Writes to r0 with ZERO_R0 off; read-after-write timing.
    cycle(1'b1, 4'd0, 16'h153a, 4'd0, 4'd0, 1'b0);
    cycle(1'b1, 4'd0, 16'h2222, 4'd0, 4'd0, 1'b0);
    check("d1 r0 after first write", 32'(o_rd_a[1]), 32'h153a);
    check("d0 r0 bypass of second write", 32'(o_rd_a[0]), 32'h2222);
    cycle(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0);
    check("d1 r0 after second write", 32'(o_rd_a[1]), 32'h2222);
    check("d2 r0 hardwired", 32'(o_rd_a[2]), 32'h0000);

    // Overwrite r8, write r14, then same-cycle bypass on r14.
    cycle(1'b1, 4'd8,  16'h1111, 4'd8, 4'd0, 1'b0);
    cycle(1'b1, 4'd8,  16'h3333, 4'd8, 4'd0, 1'b0);
    cycle(1'b1, 4'd14, 16'h5555, 4'd8, 4'd14, 1'b0);
    cycle(1'b0, 4'd0,  16'h0000, 4'd8, 4'd14, 1'b0);
    check("d0 r8", 32'(o_rd_a[0]), 32'h3333);
    check("d0 r14", 32'(o_rd_b[0]), 32'h5555);
    cycle(1'b1, 4'd14, 16'h7777, 4'd14, 4'd0, 1'b0);
    check("d0 r14 bypass", 32'(o_rd_a[0]), 32'h7777);
    check("d1 r14 no bypass", 32'(o_rd_a[1]), 32'h5555);
    check("d1 r0 port b", 32'(o_rd_b[1]), 32'h2222);

    // Hardwired r0 and a normal r1 write on d2.
    cycle(1'b1, 4'd0, 16'hffff, 4'd0, 4'd0, 1'b0);
    check("d2 r0 during write a", 32'(o_rd_a[2]), 32'h0000);
    check("d2 r0 during write b", 32'(o_rd_b[2]), 32'h0000);
    cycle(1'b1, 4'd1, 16'h00aa, 4'd0, 4'd0, 1'b0);
    cycle(1'b0, 4'd0, 16'h0000, 4'd1, 4'd0, 1'b0);
    check("d2 r1", 32'(o_rd_a[2]), 32'h00aa);
    check("d2 r0 after write", 32'(o_rd_b[2]), 32'h0000);

    // Out-of-range write on the 12-entry build.
    cycle(1'b1, 4'd13, 16'hbeef, 4'd13, 4'd13, 1'b0);
    cycle(1'b0, 4'd0,  16'h0000, 4'd13, 4'd12, 1'b0);
    check("d2 addr13 dropped", 32'(o_rd_a[2]), 32'h0000);
    check("d0 addr13 written", 32'(o_rd_a[0]), 32'hbeef);

    // Clear sweep, with a write committed in the request cycle and one
    // dropped mid-sweep.
    cycle(1'b1, 4'd5, 16'h1234, 4'd0, 4'd0, 1'b1);
    for (int c = 0; c < NDUT; c++) begin nbusy[c] = 0; ndone[c] = 0; end
    for (int i = 0; i < 20; i++) begin
      cycle(i == 6, 4'd3, 16'hdead, 4'(i % 16), 4'd3, 1'b0);
      for (int c = 0; c < NDUT; c++) begin
        nbusy[c] += int'(o_busy[c]);
        ndone[c] += int'(o_done[c]);
      end
    end
    check("d0 busy cycles", 32'(nbusy[0]), 32'd16);
    check("d1 busy cycles", 32'(nbusy[1]), 32'd16);
    check("d2 busy cycles", 32'(nbusy[2]), 32'd12);
    check("d0 done pulses", 32'(ndone[0]), 32'd1);
    check("d2 done pulses", 32'(ndone[2]), 32'd1);
    for (int a = 0; a < 16; a++) begin
      cycle(1'b0, 4'd0, 16'h0000, 4'(a), 4'(a), 1'b0);
      check($sformatf("d0 cleared r%0d", a), 32'(o_rd_a[0]), 32'h0000);
      check($sformatf("d2 cleared r%0d", a), 32'(o_rd_b[2]),
            (a == 0 || a >= 12) ? 32'h0000 : 32'h5a5a);
    end

    // Reset asserted between edges in the fifth sweep cycle.
    cycle(1'b1, 4'd7, 16'h4242, 4'd7, 4'd7, 1'b0);
    cycle(1'b0, 4'd0, 16'h0000, 4'd7, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'd0, 16'h0000, 4'd7, 4'd2, 1'b0);
    check("d0 busy before reset", 32'(o_busy[0]), 32'd1);
    #2;
    apply_reset();
    for (int c = 0; c < NDUT; c++) ndone[c] = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 4'd0, 16'h0000, 4'(i % 16), 4'd7, 1'b0);
      for (int c = 0; c < NDUT; c++) ndone[c] += int'(o_done[c]);
    end
    check("d0 no done after reset", 32'(ndone[0]), 32'd0);
    check("d2 no done after reset", 32'(ndone[2]), 32'd0);

    // Randomised traffic with occasional clears and async resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        #2;
        apply_reset();
      end
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
